fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side controller for the synchronous FIFO. It owns the FIFO read port: it issues `fifo_rd` only when data is available and buffer space is guaranteed. It absorbs the FIFO's one-cycle read latency in a small output buffer and presents the words in order on a valid/ready stream. It also reports activity and a count of delivered beats.

## Interface
- `DWIDTH`, 8: word width; matches FIFO `data_out`.
- `BUF_DEPTH`, 2: output buffer entries; minimum 2.
- `CNT_WIDTH`, 16: width of delivered-beat counter.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  drain enable.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd`  out  1  FIFO read strobe.
- `fifo_dout`  in  DWIDTH  FIFO `data_out`; valid the cycle after a read edge.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DWIDTH  output word.
- `busy`  out  1  state is not IDLE.
- `beat_count`  out  CNT_WIDTH  accepted output beats, modulo 2^CNT_WIDTH.

## Operation
- **Terms:**
  - pop = `m_valid & m_ready`.
  - occ = buffer occupancy, 0..BUF_DEPTH.
  - inflight = 1-bit register, set on any edge where `fifo_rd` was high.
- **Read issue (combinational):**
  - `fifo_rd = rst & en & !fifo_empty & (occ + inflight - pop < BUF_DEPTH)`.
  - Pop credit gives full throughput at BUF_DEPTH=2.
  - `m_ready` → `fifo_rd` is a documented combinational path.
- **Capture:** when inflight=1, `fifo_dout` is written into the buffer at the next edge, regardless of `en`.
  - A read is never issued while `fifo_empty`=1, so no read of an empty FIFO occurs.
- **Buffer:** circular, write/read pointers modulo BUF_DEPTH.
  - `m_data` = entry at the read pointer; `m_valid` = (occ≠0).
  - Simultaneous capture and pop: occ unchanged, both pointers advance.
  - Order is strictly FIFO; no word is dropped or duplicated.
- **State machine:**
  - IDLE: en=0, occ=0, inflight=0. Goes to ACTIVE when en=1.
  - ACTIVE: en=1. When en=0, goes to DRAIN if occ or inflight is nonzero, else IDLE.
  - DRAIN: no new reads; delivers the remaining words. Goes to IDLE when occ=0 and inflight=0; returns to ACTIVE if en=1.
- **beat_count:** increments by 1 on every pop; wraps to 0 past 2^CNT_WIDTH−1.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, occ=0, inflight=0, pointers 0, `beat_count`=0.
  - `m_valid`=0, `m_data`=0, `busy`=0.
  - `fifo_rd` is forced 0 while rst=0.
- Reset mid-operation discards buffered and in-flight words. The FIFO data consumed by an already-issued read is lost; this is by design.
- Latency: `fifo_rd` high in cycle N → `m_valid` high in cycle N+2 with that word.
- Sustained throughput is 1 word/cycle with `m_ready`=1 and the FIFO non-empty.
- Backpressure: with `m_ready`=0, at most BUF_DEPTH words are read ahead.
  - `m_data` and `m_valid` hold stable until pop.
- `en` deassert takes effect in the same cycle on `fifo_rd`. Words already read are still delivered.
- `busy` is registered; it follows the state after each edge.

## Structure
- Package `fifo_pkg`:
  - `DWIDTH` default constant shared with the FIFO.
  - `typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} drain_state_t`.
- One sub-module, `stream_buf`: the BUF_DEPTH circular buffer with occ, push/pop, and `m_valid`/`m_data`.
  - `fifo_drain` holds the FSM, the read-issue logic, inflight and `beat_count`.

## Test plan
- **Stream:** FIFO preloaded with 0x11..0x1A, en=1, m_ready=1 →
  - `fifo_rd` high exactly 10 cycles.
  - First `m_valid` 2 cycles after the first `fifo_rd`.
  - 10 consecutive beats 0x11..0x1A in order; `beat_count`=10; then IDLE, `busy`=0.
- **Backpressure:** 10 words loaded, m_ready=0 for 6 cycles →
  - Exactly 2 reads issued; `m_data`=0x11 held.
  - After m_ready=1, all 10 words arrive in order with no gap beyond the 2 buffered.
- **Enable drop:** en drops after the 3rd `fifo_rd` →
  - No further reads; DRAIN lasts until 3 words are delivered, then IDLE.
  - The FIFO still holds 7 words.
- **Empty toggling:** writer supplies 1 word every 3 cycles, en=1 →
  - `fifo_rd` only when `fifo_empty`=0; every word appears 2 cycles after its read.
  - No read while empty.
- **Reset mid-stream:** rst=0 with occ=2 →
  - `m_valid`=0 and `beat_count`=0 immediately.
  - After release, the next output is the next FIFO word.
- **Counter wrap:** CNT_WIDTH=4, 17 beats → `beat_count`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side drain controller.
package fifo_pkg;

  // Word width shared by the FIFO data_out and the drain output stream.
  localparam int FIFO_DWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } drain_state_t;

endpackage

// File: rtl/stream_buf.sv
// Circular output buffer that absorbs the FIFO read latency and presents
// words on a valid/ready stream in strict arrival order.
module stream_buf
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = FIFO_DWIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             push,
  input  logic [DWIDTH-1:0]                push_data,
  input  logic                             m_ready,
  output logic                             m_valid,
  output logic [DWIDTH-1:0]                m_data,
  output logic                             pop,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occ
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  // Output reads as zero while empty so stale storage never leaks out.
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // Buffer control: pointers and occupancy.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage: data only, no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  no_overflow: assert property (@(posedge clock) disable iff (!rst)
    push |-> (occ != OCC_W'(BUF_DEPTH)) || pop);

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for the synchronous FIFO: issues reads with buffer
// credit, tracks the in-flight read, runs IDLE/ACTIVE/DRAIN and counts beats.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = FIFO_DWIDTH,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [DWIDTH-1:0]    fifo_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DWIDTH-1:0]    m_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] beat_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  drain_state_t     state;
  drain_state_t     state_nxt;
  logic             inflight;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   credit;

  // Words already committed (buffered or in flight) minus the one leaving now;
  // counting the pop lets a read issue every cycle at BUF_DEPTH=2.
  assign credit  = {1'b0, occ} + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);
  assign fifo_rd = rst & en & ~fifo_empty & (credit < (OCC_W + 1)'(BUF_DEPTH));

  // Stage 1: read issued last edge, FIFO data valid this cycle.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= fifo_rd;
  end

  // Stage 2: capture into the output buffer.
  stream_buf #(
    .DWIDTH    (DWIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock     (clock),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .pop       (pop),
    .occ       (occ)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!en) state_nxt = ((occ != '0) || inflight) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (en)                             state_nxt = ACTIVE;
        else if ((occ == '0) && !inflight)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)     beat_count <= '0;
    else if (pop) beat_count <= beat_count + CNT_WIDTH'(1);
  end

  no_empty_read: assert property (@(posedge clock) disable iff (!rst)
    fifo_rd |-> !fifo_empty);

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a behavioural FIFO and outstanding-word scoreboard
// checked every cycle by a monitor process, driven by directed and random phases.
module tb_fifo_drain;

  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [CW-1:0] beat_count;

  logic          wr_en;
  logic [DW-1:0] wr_data;

  always #5 clock = ~clock;

  fifo_drain #(
    .DWIDTH    (DW),
    .BUF_DEPTH (BD),
    .CNT_WIDTH (CW)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .beat_count (beat_count)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            rc;
  } exp_t;

  logic [DW-1:0] fq[$];
  exp_t          exq[$];
  int            cyc   = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_rd  = 0;
  int            n_pop = 0;
  logic [CW-1:0] exp_cnt;
  logic          exp_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // A word read in cycle rc is presented from cycle rc+2 once all older words are gone.
  task automatic monitor();
    logic          ev, pop_s, rd_s, wr_s;
    logic [DW-1:0] wd, w;
    int            outst;
    forever begin
      @(negedge clock);
      if (!rst) begin
        exq.delete();
        exp_cnt  = '0;
        exp_busy = 1'b0;
      end
      ev = 1'b0;
      if (exq.size() > 0) ev = (cyc >= exq[0].rc + 2);
      pop_s = ev && m_ready;
      outst = exq.size();
      chk("m_valid", m_valid, ev);
      if (ev) chk("m_data", m_data, exq[0].d);
      chk("fifo_rd", fifo_rd,
          rst && en && (fq.size() > 0) && (outst - (pop_s ? 1 : 0) < BD));
      chk("beat_count", beat_count, exp_cnt);
      chk("busy", busy, exp_busy);
      rd_s = (fifo_rd === 1'b1);
      wr_s = wr_en;
      wd   = wr_data;
      if (rst && rd_s) n_rd++;
      @(posedge clock);
      if (rst) begin
        exp_busy = en || (exp_busy && outst > 0);
        if (pop_s) begin
          void'(exq.pop_front());
          exp_cnt = exp_cnt + 1'b1;
          n_pop++;
        end
        if (rd_s && fq.size() > 0) begin
          w = fq.pop_front();
          exq.push_back('{w, cyc});
          fifo_dout <= w;
        end
      end
      if (wr_s) fq.push_back(wd);
      fifo_empty <= (fq.size() == 0);
      cyc++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + DW'(i);
      step(1);
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string nm);
    int t;
    t = 0;
    while (n_pop < target && t < budget) begin
      step(1);
      t++;
    end
    chk({nm, "_done"}, 32'(n_pop >= target), 1);
  endtask

  initial begin
    int r0, p0, c0, t;
    rst        = 1'b0;
    en         = 1'b0;
    m_ready    = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    exp_cnt    = '0;
    exp_busy   = 1'b0;
    fork
      monitor();
    join_none

    step(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat", beat_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    step(1);

    // Stream: 10 words back to back.
    load(10, 8'h11);
    r0 = n_rd; p0 = n_pop; c0 = cyc;
    en = 1'b1; m_ready = 1'b1;
    wait_pops(p0 + 10, 20, "stream");
    chk("stream_cycles", cyc - c0, 12);
    chk("stream_reads", n_rd - r0, 10);
    chk("stream_beat", beat_count, 10);
    en = 1'b0;
    step(1);
    chk("stream_idle", busy, 0);

    // Backpressure: only BD words read ahead, head held.
    load(10, 8'h21);
    r0 = n_rd; p0 = n_pop;
    en = 1'b1; m_ready = 1'b0;
    step(6);
    chk("bp_reads", n_rd - r0, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h21);
    m_ready = 1'b1; c0 = cyc;
    wait_pops(p0 + 10, 20, "bp");
    chk("bp_cycles", cyc - c0, 10);
    en = 1'b0;
    step(2);

    // Enable drop after the third read.
    load(10, 8'h31);
    r0 = n_rd; p0 = n_pop;
    en = 1'b1; m_ready = 1'b1;
    t = 0;
    while (n_rd - r0 < 3 && t < 10) begin step(1); t++; end
    en = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 20) begin step(1); t++; end
    chk("drop_reads", n_rd - r0, 3);
    chk("drop_pops", n_pop - p0, 3);
    chk("drop_left", fq.size(), 7);
    en = 1'b1;
    wait_pops(p0 + 10, 20, "drop_rest");
    en = 1'b0;
    step(2);

    // Trickle writer: one word every third cycle.
    r0 = n_rd; p0 = n_pop;
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h41 + 8'(i);
      step(1);
      wr_en = 1'b0;
      step(2);
    end
    step(4);
    chk("trickle_reads", n_rd - r0, 8);
    chk("trickle_pops", n_pop - p0, 8);
    en = 1'b0;
    step(2);

    // Reset with two words buffered.
    load(6, 8'h51);
    en = 1'b1; m_ready = 1'b0;
    step(4);
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_beat", beat_count, 0);
    chk("mid_rst_busy", busy, 0);
    step(2);
    rst = 1'b1; m_ready = 1'b1;
    p0 = n_pop;
    t = 0;
    while (m_valid !== 1'b1 && t < 6) begin step(1); t++; end
    chk("post_rst_word", m_data, 8'h53);
    wait_pops(p0 + 4, 12, "post_rst");
    en = 1'b0;
    step(2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = DW'($urandom);
      step(1);
    end
    wr_en = 1'b0; en = 1'b1; m_ready = 1'b1;
    t = 0;
    while ((fq.size() > 0 || m_valid === 1'b1) && t < 300) begin step(1); t++; end
    chk("rand_drained", 32'(fq.size() == 0 && m_valid === 1'b0), 1);
    en = 1'b0;
    step(3);

    // Counter wrap at CW=4.
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    p0 = n_pop;
    load(17, 8'h70);
    en = 1'b1; m_ready = 1'b1;
    wait_pops(p0 + 17, 30, "wrap");
    en = 1'b0;
    step(2);
    chk("wrap_count", beat_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
